ascii_uart_tx: RTL and testbench
================================

ASCII_UART_TX -- requirements
Module: ascii_uart_tx

Interface
REQ-001 Parameters SHALL be, one per line:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- NUM_CHARS, 4, ASCII characters per frame group, taken from ascii_in.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ascii_in  in  32  four ASCII characters from the BCD converter; [31:24] sent first.
- ascii_valid  in  1  converter ready flag; may be a 1-cycle pulse or a held level.
- tx  out  1  UART serial line, 8N1, idle high.
- busy  out  1  high while a group is being transmitted.
- done  out  1  1-cycle pulse when the final stop bit of a group completes.
- overrun  out  1  1-cycle pulse when an ascii_valid rising edge is dropped.
REQ-003 Clock and reset SHALL be one clock (clk) and a synchronous active-high reset (rst); no other clock or async reset.

Function
REQ-004 A rising edge of ascii_valid SHALL be detected by registering ascii_valid (valid_q) and computing ascii_valid & ~valid_q.
REQ-005 An edge in a cycle where state==IDLE SHALL latch ascii_in into a 32-bit hold register and go to START_BIT on that clock edge; busy SHALL be high from the next cycle.
REQ-006 An edge while state!=IDLE SHALL be ignored, with the hold register unchanged and overrun pulsed for one cycle.
REQ-007 The FSM states SHALL be IDLE, START_BIT, DATA, STOP_BIT, NEXT_CHAR.
- IDLE->START_BIT on an accepted edge.
- START_BIT->DATA after CLKS_PER_BIT cycles.
- DATA->STOP_BIT after 8 bits.
- STOP_BIT->NEXT_CHAR after CLKS_PER_BIT cycles.
- NEXT_CHAR->START_BIT if characters remain, else ->IDLE.
REQ-008 NEXT_CHAR SHALL last exactly one cycle, with tx held high.
REQ-009 tx SHALL be a registered output.
- Start bit 0; data LSB first; stop bit 1.
- Each bit held exactly CLKS_PER_BIT cycles.
REQ-010 The bit-timing counter SHALL be $clog2(CLKS_PER_BIT) bits wide, reload to 0 at each bit boundary, and never wrap mid-bit.
REQ-011 Characters SHALL be sent in the order ascii_in[31:24], [23:16], [15:8], [7:0]; the character index SHALL be 3 bits wide.
REQ-012 A 4-character group SHALL take exactly 4*(10*CLKS_PER_BIT+1) cycles from the first start-bit cycle to the IDLE return.
REQ-013 done SHALL pulse in the cycle the FSM re-enters IDLE; busy SHALL fall in that same cycle.
REQ-014 An ascii_valid edge coincident with done SHALL be accepted, because state==IDLE in that cycle.
REQ-015 A held-high ascii_valid SHALL start exactly one group and SHALL NOT retrigger.
REQ-016 ascii_in changes after the latch cycle SHALL NOT affect the group in flight.

Reset
REQ-017 In any state, rst=1 at a clock edge SHALL force the following on the next cycle:
- state=IDLE, tx=1, busy=0, done=0, overrun=0.
- Hold register, counters and valid_q all 0.
REQ-018 Reset mid-character SHALL abort the frame immediately, with no stop bit completed and no done pulse.
REQ-019 If ascii_valid is high when rst falls, an edge SHALL be detected in the first cycle after reset, because valid_q resets to 0.

Configuration
REQ-020 Macro ASCII_UART_TX_CRLF_EN, when defined, SHALL append 0x0D then 0x0A after the four characters.
- Group becomes 6 characters lasting 6*(10*CLKS_PER_BIT+1) cycles.
- done pulses after the LF stop bit.
REQ-021 When ASCII_UART_TX_CRLF_EN is undefined, exactly four characters SHALL be sent, with no CR/LF logic synthesised.

Structure
REQ-022 Package ascii_uart_tx_pkg SHALL hold:
- the FSM state enum typedef;
- constants ASCII_CR=8'h0D and ASCII_LF=8'h0A;
- the character-count constants (4 and 6).
REQ-023 A sub-module uart_tx_bit_timer SHALL provide the CLKS_PER_BIT counter and a bit_tick pulse; character and bit sequencing SHALL stay in ascii_uart_tx.

Verification (CLKS_PER_BIT=4)
REQ-024 Single group: ascii_in=0x31323334 with a 1-cycle valid pulse -> tx carries bytes 0x31,0x32,0x33,0x34 in order, 8N1, 4 cycles/bit; done pulses once after 164 cycles; busy is high throughout.
REQ-025 Overrun: a second valid pulse 20 cycles into a group -> overrun pulses 1 cycle; the first group completes unchanged; no second group starts.
REQ-026 Back-to-back: a valid edge in the done cycle with ascii_in=0x30303030 -> the next start bit follows with no idle gap beyond 1 cycle; four 0x30 bytes are sent.
REQ-027 Reset mid-DATA of the second character -> tx=1 and busy=0 the next cycle; no done pulse; a new valid afterwards sends a full clean group.
REQ-028 With ASCII_UART_TX_CRLF_EN: ascii_in=0x30303432 -> bytes 0x30,0x30,0x34,0x32,0x0D,0x0A; done pulses after 246 cycles.
REQ-029 Held level: ascii_valid held high for 500 cycles -> exactly one group is sent and overrun never pulses.

Source files
------------

// File: rtl/ascii_uart_tx_pkg.sv
// Shared types and constants for the ASCII UART transmitter.
// ASCII_UART_TX_CRLF_EN adds a CR/LF tail to every character group.
package ascii_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    STOP_BIT,
    NEXT_CHAR
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int NUM_CHARS_BASE = 4;
  localparam int NUM_CHARS_CRLF = 6;

  // Character idx of a group: index 0 is the most significant byte of the hold register.
  function automatic logic [7:0] group_char(input logic [31:0] hold, input logic [2:0] idx);
    case (idx)
      3'd0:    group_char = hold[31:24];
      3'd1:    group_char = hold[23:16];
      3'd2:    group_char = hold[15:8];
      3'd3:    group_char = hold[7:0];
`ifdef ASCII_UART_TX_CRLF_EN
      3'd4:    group_char = ASCII_CR;
      3'd5:    group_char = ASCII_LF;
`endif
      default: group_char = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period counter: bit_tick pulses on the last clk cycle of each UART bit.
// The count restarts from 0 whenever the timer is disabled or a bit ends.
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = en && (cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !en || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ascii_uart_tx.sv
// Sends a group of ASCII characters from ascii_in as 8N1 UART frames, MSB byte first.
// Define ASCII_UART_TX_CRLF_EN to append CR and LF to every group.
module ascii_uart_tx
  import ascii_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_CHARS    = NUM_CHARS_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ascii_in,
  input  logic        ascii_valid,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

`ifdef ASCII_UART_TX_CRLF_EN
  localparam int TOTAL_CHARS = NUM_CHARS + (NUM_CHARS_CRLF - NUM_CHARS_BASE);
`else
  localparam int TOTAL_CHARS = NUM_CHARS;
`endif
  localparam logic [2:0] LAST_CHAR = 3'(TOTAL_CHARS - 1);

  state_t      state, state_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [2:0]  char_idx, char_idx_d;
  logic [31:0] hold;
  logic [7:0]  cur_char;
  logic        valid_q, valid_edge;
  logic        timer_en, bit_tick;
  logic        tx_d, done_d, overrun_d;

  assign valid_edge = ascii_valid & ~valid_q;
  assign timer_en   = (state == START_BIT) || (state == DATA) || (state == STOP_BIT);
  assign busy       = (state != IDLE);

  uart_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (timer_en),
    .bit_tick(bit_tick)
  );

  // NOTE: the hold register is an ordinary flop bank, not a memory, so it is cleared by reset like the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_idx  <= '0;
      char_idx <= '0;
      hold     <= '0;
      valid_q  <= 1'b0;
      tx       <= 1'b1;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_d;
      bit_idx  <= bit_idx_d;
      char_idx <= char_idx_d;
      valid_q  <= ascii_valid;
      if (state == IDLE && valid_edge) begin
        hold <= ascii_in;
      end
      tx       <= tx_d;
      done     <= done_d;
      overrun  <= overrun_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state;
    bit_idx_d  = bit_idx;
    char_idx_d = char_idx;
    case (state)
      IDLE: begin
        bit_idx_d  = '0;
        char_idx_d = '0;
        if (valid_edge) state_d = START_BIT;
      end
      START_BIT: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == 3'd7) begin
            state_d   = STOP_BIT;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      STOP_BIT: begin
        if (bit_tick) state_d = NEXT_CHAR;
      end
      NEXT_CHAR: begin
        if (char_idx == LAST_CHAR) begin
          state_d    = IDLE;
          char_idx_d = '0;
        end else begin
          state_d    = START_BIT;
          char_idx_d = char_idx + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is computed from the next state so the registered line changes together with the FSM.
  always_comb begin
    cur_char = group_char(hold, char_idx_d);
    case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA:      tx_d = cur_char[bit_idx_d];
      default:   tx_d = 1'b1;
    endcase
    done_d    = (state == NEXT_CHAR) && (state_d == IDLE);
    overrun_d = valid_edge && (state != IDLE);
  end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Scoreboard bench for ascii_uart_tx at CLKS_PER_BIT=4: a line monitor decodes
// frames from tx and each scenario task compares them with the bytes it pushed.
module tb_ascii_uart_tx;

  localparam int CPB = 4;
`ifdef ASCII_UART_TX_CRLF_EN
  localparam int NCH = 6;
`else
  localparam int NCH = 4;
`endif
  localparam int FRAME_CYCLES = 10 * CPB;
  localparam int GROUP_CYCLES = NCH * (10 * CPB + 1);
  localparam int BUDGET       = 2 * GROUP_CYCLES + 50;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       glitch;
    longint     start_cyc;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ascii_in;
  logic        ascii_valid;
  logic        tx, busy, done, overrun;

  int     tests = 0;
  int     fails = 0;
  int     done_cnt = 0;
  int     ovr_cnt = 0;
  longint cyc = 0;

  logic [7:0] exp_q[$];
  frame_t     rx_q[$];

  bit         in_frame = 1'b0;
  int         fidx = 0;
  logic [9:0] bits;
  logic       glitch;
  longint     fstart;

  ascii_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ascii_in   (ascii_in),
    .ascii_valid(ascii_valid),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: decodes 8N1 frames and flags any bit that changes inside its period.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
      if (rst === 1'b1) begin
        in_frame = 1'b0;
      end else if (in_frame || tx === 1'b0) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          fidx     = 0;
          glitch   = 1'b0;
          fstart   = cyc;
        end
        if (fidx % CPB == 0) bits[fidx / CPB] = tx;
        else if (tx !== bits[fidx / CPB]) glitch = 1'b1;
        fidx++;
        if (fidx == FRAME_CYCLES) begin
          frame_t fr;
          in_frame     = 1'b0;
          fr.data      = bits[8:1];
          fr.stop      = bits[9];
          fr.glitch    = glitch;
          fr.start_cyc = fstart;
          rx_q.push_back(fr);
        end
      end
    end
  end

  task automatic push_group(input logic [31:0] data);
    for (int i = 3; i >= 0; i--) exp_q.push_back(data[8*i +: 8]);
`ifdef ASCII_UART_TX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic pulse_valid(input logic [31:0] data);
    @(posedge clk);
    #1;
    ascii_in    = data;
    ascii_valid = 1'b1;
    @(posedge clk);
    #1;
    ascii_valid = 1'b0;
    ascii_in    = ~data;
  endtask

  task automatic wait_done(input int budget, output bit ok, output longint at, output int busy_gaps);
    ok = 1'b0;
    at = 0;
    busy_gaps = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      if (busy !== 1'b1) busy_gaps++;
    end
  endtask

  task automatic pop_pair(output logic [7:0] exp_b, output frame_t got, output bit have);
    have = (exp_q.size() > 0) && (rx_q.size() > 0);
    exp_b = 8'hxx;
    got.data = 8'hxx;
    got.stop = 1'bx;
    got.glitch = 1'b0;
    got.start_cyc = -1;
    if (exp_q.size() > 0) exp_b = exp_q.pop_front();
    if (rx_q.size() > 0) got = rx_q.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ascii_valid = 1'b0;
    ascii_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_single();
    bit ok; longint at, first; int gaps, d0; logic [7:0] eb; frame_t fr; bit have;
    d0 = done_cnt;
    push_group(32'h31323334);
    pulse_valid(32'h31323334);
    wait_done(BUDGET, ok, at, gaps);
    tests++; if (!ok) begin fails++; $display("FAIL single_done: no done within %0d cycles", BUDGET); end
    tests++; if (gaps != 0) begin fails++; $display("FAIL single_busy: busy low in %0d cycles, expected 0", gaps); end
    first = -1;
    for (int i = 0; i < NCH; i++) begin
      pop_pair(eb, fr, have);
      if (i == 0) first = fr.start_cyc;
      tests++;
      if (!have || fr.data !== eb || fr.stop !== 1'b1 || fr.glitch !== 1'b0) begin
        fails++;
        $display("FAIL single_char%0d: got %h stop=%b glitch=%b present=%b expected %h", i, fr.data, fr.stop, fr.glitch, have, eb);
      end
    end
    tests++; if (at - first != GROUP_CYCLES) begin fails++; $display("FAIL single_length: got %0d cycles expected %0d", at - first, GROUP_CYCLES); end
    repeat (30) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 1 || rx_q.size() != 0) begin
      fails++;
      $display("FAIL single_once: done pulses %0d extra frames %0d, expected 1 and 0", done_cnt - d0, rx_q.size());
    end
  endtask

  task automatic test_overrun();
    bit ok; longint at; int gaps, o0; logic [7:0] eb; frame_t fr; bit have;
    push_group(32'h41424344);
    pulse_valid(32'h41424344);
    repeat (18) @(posedge clk);
    o0 = ovr_cnt;
    pulse_valid(32'h5A5A5A5A);
    @(negedge clk);
    @(negedge clk);
    tests++; if (ovr_cnt - o0 != 1) begin fails++; $display("FAIL overrun_pulse: got %0d cycles high expected 1", ovr_cnt - o0); end
    wait_done(BUDGET, ok, at, gaps);
    tests++; if (!ok) begin fails++; $display("FAIL overrun_done: no done within %0d cycles", BUDGET); end
    for (int i = 0; i < NCH; i++) begin
      pop_pair(eb, fr, have);
      tests++;
      if (!have || fr.data !== eb || fr.stop !== 1'b1 || fr.glitch !== 1'b0) begin
        fails++;
        $display("FAIL overrun_char%0d: got %h stop=%b glitch=%b present=%b expected %h", i, fr.data, fr.stop, fr.glitch, have, eb);
      end
    end
    repeat (60) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || rx_q.size() != 0) begin
      fails++;
      $display("FAIL overrun_no_second: busy=%b extra frames %0d, expected 0 and 0", busy, rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2; longint at1, at2, second; int gaps; logic [7:0] eb; frame_t fr; bit have;
    push_group(32'h31323334);
    pulse_valid(32'h31323334);
    wait_done(BUDGET, ok1, at1, gaps);
    ascii_in = 32'h30303030;
    ascii_valid = 1'b1;
    push_group(32'h30303030);
    @(posedge clk);
    #1;
    ascii_valid = 1'b0;
    ascii_in = '1;
    tests++; if (!ok1) begin fails++; $display("FAIL b2b_first_done: no done within %0d cycles", BUDGET); end
    wait_done(BUDGET, ok2, at2, gaps);
    tests++; if (!ok2) begin fails++; $display("FAIL b2b_second_done: no done within %0d cycles", BUDGET); end
    second = -1;
    for (int i = 0; i < 2 * NCH; i++) begin
      pop_pair(eb, fr, have);
      if (i == NCH) second = fr.start_cyc;
      tests++;
      if (!have || fr.data !== eb || fr.stop !== 1'b1 || fr.glitch !== 1'b0) begin
        fails++;
        $display("FAIL b2b_char%0d: got %h stop=%b glitch=%b present=%b expected %h", i, fr.data, fr.stop, fr.glitch, have, eb);
      end
    end
    tests++; if (second - at1 != 1) begin fails++; $display("FAIL b2b_gap: start %0d cycles after done, expected 1", second - at1); end
  endtask

  task automatic test_reset_mid();
    bit ok; longint at, first; int gaps, d0; logic [7:0] eb; frame_t fr; bit have;
    exp_q.push_back(8'h55);
    pulse_valid(32'h55AA0F3C);
    repeat (54) @(posedge clk);
    #1 rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    repeat (GROUP_CYCLES) @(negedge clk);
    tests++; if (done_cnt != d0) begin fails++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt - d0); end
    pop_pair(eb, fr, have);
    tests++;
    if (!have || fr.data !== eb || fr.stop !== 1'b1 || rx_q.size() != 0) begin
      fails++;
      $display("FAIL rstmid_frames: first %h present=%b, %0d extra frames, expected %h and 0", fr.data, have, rx_q.size(), eb);
    end
    rx_q.delete();
    exp_q.delete();
    push_group(32'h41424344);
    pulse_valid(32'h41424344);
    wait_done(BUDGET, ok, at, gaps);
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_clean_done: no done within %0d cycles", BUDGET); end
    first = -1;
    for (int i = 0; i < NCH; i++) begin
      pop_pair(eb, fr, have);
      if (i == 0) first = fr.start_cyc;
      tests++;
      if (!have || fr.data !== eb || fr.stop !== 1'b1 || fr.glitch !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_char%0d: got %h stop=%b glitch=%b present=%b expected %h", i, fr.data, fr.stop, fr.glitch, have, eb);
      end
    end
    tests++; if (at - first != GROUP_CYCLES) begin fails++; $display("FAIL rstmid_length: got %0d cycles expected %0d", at - first, GROUP_CYCLES); end
  endtask

  task automatic test_held();
    int d0, o0; logic [7:0] eb; frame_t fr; bit have;
    push_group(32'h39383736);
    d0 = done_cnt;
    o0 = ovr_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    ascii_valid = 1'b1;
    ascii_in = 32'h39383736;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      fails++;
      $display("FAIL held_edge_after_reset: busy=%b tx=%b expected busy=1 tx=0", busy, tx);
    end
    repeat (497) @(posedge clk);
    #1 ascii_valid = 1'b0;
    repeat (40) @(negedge clk);
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL held_done_count: got %0d expected 1", done_cnt - d0); end
    tests++; if (ovr_cnt != o0) begin fails++; $display("FAIL held_overrun: got %0d pulses expected 0", ovr_cnt - o0); end
    for (int i = 0; i < NCH; i++) begin
      pop_pair(eb, fr, have);
      tests++;
      if (!have || fr.data !== eb || fr.stop !== 1'b1 || fr.glitch !== 1'b0) begin
        fails++;
        $display("FAIL held_char%0d: got %h stop=%b glitch=%b present=%b expected %h", i, fr.data, fr.stop, fr.glitch, have, eb);
      end
    end
    tests++; if (rx_q.size() != 0) begin fails++; $display("FAIL held_single_group: got %0d extra frames expected 0", rx_q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    ascii_valid = 1'b0;
    ascii_in = '0;
    test_reset();
    test_single();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
